// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   ptr_w(depth)  - read/write pointer width for a given depth
//   cnt_w(depth)  - occupancy counter width (must hold 0..depth)
//   FIFO_STD/FIFO_FWFT - read-mode selectors for the FWFT parameter
//   fifo_err_t    - sticky error flag pair
package fifo_pkg;

  localparam bit FIFO_STD  = 1'b0;
  localparam bit FIFO_FWFT = 1'b1;

  typedef struct packed {
    logic overrun;
    logic underrun;
  } fifo_err_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side bundle of the synchronous FIFO.
//   master : the user side (drives we/w_data/re/clr_err)
//   slave  : the FIFO side (drives read data, flags, count, errors)
interface sync_fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  logic                                 we;
  logic [DATA_WIDTH-1:0]                w_data;
  logic                                 re;
  logic [DATA_WIDTH-1:0]                r_data;
  logic                                 r_valid;
  logic                                 full;
  logic                                 empty;
  logic                                 almost_full;
  logic                                 almost_empty;
  logic [fifo_pkg::cnt_w(DEPTH)-1:0]    count;
  logic                                 overrun;
  logic                                 underrun;
  logic                                 clr_err;

  modport master (
    output we, w_data, re, clr_err,
    input  r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overrun, underrun
  );

  modport slave (
    input  we, w_data, re, clr_err,
    output r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overrun, underrun
  );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read.
//   clk   - write clock
//   we    - write enable, waddr/wdata - write port
//   raddr - read address, rdata - combinational read data
// Storage is intentionally not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// thresholds, sticky overrun/underrun flags and selectable FWFT read mode.
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - slave side of sync_fifo_param_if (we/w_data/re/clr_err in;
//         r_data/r_valid/full/empty/almost_*/count/overrun/underrun out)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2,
  parameter bit          FWFT       = FIFO_STD
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be below AF_THRESH");
  end

  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  fifo_err_t             err_q, err_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  empty, full, rd_ok, wr_ok;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wp_q),
    .wdata (bus.w_data),
    .raddr (rp_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == DEPTH_C);
    rd_ok = bus.re && !empty;
    // A write into a full FIFO is still accepted when a read frees a slot
    // on the same edge.
    wr_ok = bus.we && (!full || rd_ok);

    wp_d     = wr_ok ? wp_q + PW'(1) : wp_q;
    rp_d     = rd_ok ? rp_q + PW'(1) : rp_q;
    cnt_d    = cnt_q;
    if (wr_ok && !rd_ok) cnt_d = cnt_q + CW'(1);
    if (rd_ok && !wr_ok) cnt_d = cnt_q - CW'(1);

    rdata_d  = rd_ok ? ram_rdata : rdata_q;
    rvalid_d = rd_ok;

    // Set takes priority over clear.
    err_d.overrun  = (err_q.overrun  && !bus.clr_err) || (bus.we && full && !rd_ok);
    err_d.underrun = (err_q.underrun && !bus.clr_err) || (bus.re && empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.r_data       = (FWFT == FIFO_FWFT) ? ram_rdata : rdata_q;
  assign bus.r_valid      = (FWFT == FIFO_FWFT) ? !empty    : rvalid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt_q >= AF_C);
  assign bus.almost_empty = (cnt_q <= AE_C);
  assign bus.count        = cnt_q;
  assign bus.overrun      = err_q.overrun;
  assign bus.underrun     = err_q.underrun;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT
// instance, DEPTH=16, AF=14, AE=2, 8-bit data.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) if_s ();
  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) if_f ();

  sync_fifo_param #(
    .DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  sync_fifo_param #(
    .DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (if_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_s.we = 1'b0; if_s.re = 1'b0; if_s.clr_err = 1'b0; if_s.w_data = '0;
    if_f.we = 1'b0; if_f.re = 1'b0; if_f.clr_err = 1'b0; if_f.w_data = '0;
    #12;
    check("rst_count",    32'(if_s.count), 0);
    check("rst_empty",    32'(if_s.empty), 1);
    check("rst_full",     32'(if_s.full), 0);
    check("rst_ae",       32'(if_s.almost_empty), 1);
    check("rst_af",       32'(if_s.almost_full), 0);
    check("rst_rvalid",   32'(if_s.r_valid), 0);
    check("rst_rdata",    32'(if_s.r_data), 0);
    check("rst_overrun",  32'(if_s.overrun), 0);
    check("rst_underrun", 32'(if_s.underrun), 0);
    check("rst_f_rvalid", 32'(if_f.r_valid), 0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      if_s.we = 1'b1; if_s.w_data = 8'(i);
      tick();
      check("fill_af", 32'(if_s.almost_full), 32'(i >= 14));
      check("fill_ae", 32'(if_s.almost_empty), 32'(i <= 2));
    end
    if_s.we = 1'b0;
    check("fill_count", 32'(if_s.count), 16);
    check("fill_full",  32'(if_s.full), 1);
    check("fill_empty", 32'(if_s.empty), 0);

    // Write at full
    if_s.we = 1'b1; if_s.w_data = 8'hFF;
    tick();
    if_s.we = 1'b0;
    check("ovr_flag",  32'(if_s.overrun), 1);
    check("ovr_count", 32'(if_s.count), 16);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      if_s.re = 1'b1;
      tick();
      check("drain_data",   32'(if_s.r_data), 32'(i));
      check("drain_rvalid", 32'(if_s.r_valid), 1);
    end
    if_s.re = 1'b0;
    tick();
    check("drain_rvalid_drop", 32'(if_s.r_valid), 0);
    check("drain_rdata_hold",  32'(if_s.r_data), 32'h10);
    check("drain_empty",       32'(if_s.empty), 1);
    check("drain_overrun",     32'(if_s.overrun), 1);
    if_s.clr_err = 1'b1;
    tick();
    if_s.clr_err = 1'b0;
    check("clr_overrun", 32'(if_s.overrun), 0);

    // Read+write at empty: write accepted, read rejected
    if_s.we = 1'b1; if_s.re = 1'b1; if_s.w_data = 8'h3C;
    tick();
    if_s.we = 1'b0; if_s.re = 1'b0;
    check("unr_flag",   32'(if_s.underrun), 1);
    check("unr_count",  32'(if_s.count), 1);
    check("unr_rvalid", 32'(if_s.r_valid), 0);
    if_s.re = 1'b1;
    tick();
    if_s.re = 1'b0;
    check("unr_data",   32'(if_s.r_data), 32'h3C);
    check("unr_rvalid2", 32'(if_s.r_valid), 1);
    check("unr_count2", 32'(if_s.count), 0);
    if_s.clr_err = 1'b1;
    tick();
    if_s.clr_err = 1'b0;
    check("clr_underrun", 32'(if_s.underrun), 0);

    // Full with simultaneous read+write
    for (int i = 0; i < 16; i++) begin
      if_s.we = 1'b1; if_s.w_data = 8'(32'h20 + i);
      tick();
    end
    if_s.re = 1'b1; if_s.w_data = 8'h99;
    tick();
    if_s.we = 1'b0; if_s.re = 1'b0;
    check("fullrw_count",   32'(if_s.count), 16);
    check("fullrw_overrun", 32'(if_s.overrun), 0);
    check("fullrw_data",    32'(if_s.r_data), 32'h20);
    check("fullrw_rvalid",  32'(if_s.r_valid), 1);
    for (int i = 1; i <= 16; i++) begin
      if_s.re = 1'b1;
      tick();
      check("fullrw_drain", 32'(if_s.r_data), (i == 16) ? 32'h99 : 32'(32'h20 + i));
    end
    if_s.re = 1'b0;
    check("fullrw_empty", 32'(if_s.count), 0);

    // 40 streamed words across pointer wrap
    for (int k = 0; k <= 40; k++) begin
      if_s.we = (k < 40); if_s.w_data = 8'(32'h40 + k);
      if_s.re = (k >= 1);
      tick();
      if (k >= 1) check("wrap_data", 32'(if_s.r_data), 32'(32'h40 + k - 1));
    end
    if_s.we = 1'b0; if_s.re = 1'b0;
    check("wrap_count", 32'(if_s.count), 0);
    check("wrap_errs",  32'({if_s.overrun, if_s.underrun}), 0);

    // Asynchronous reset mid-stream at count=9 with r_valid in flight
    for (int i = 0; i < 10; i++) begin
      if_s.we = 1'b1; if_s.w_data = 8'(i);
      tick();
    end
    if_s.we = 1'b0; if_s.re = 1'b1;
    tick();
    if_s.re = 1'b0;
    check("mid_count_pre",  32'(if_s.count), 9);
    check("mid_rvalid_pre", 32'(if_s.r_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_count",  32'(if_s.count), 0);
    check("mid_empty",  32'(if_s.empty), 1);
    check("mid_rvalid", 32'(if_s.r_valid), 0);
    @(negedge clk) rst = 1'b1;
    tick();

    // FWFT instance
    check("fw_rvalid0", 32'(if_f.r_valid), 0);
    if_f.we = 1'b1; if_f.w_data = 8'hA5;
    tick();
    if_f.we = 1'b0;
    check("fw_rvalid", 32'(if_f.r_valid), 1);
    check("fw_data",   32'(if_f.r_data), 32'hA5);
    tick();
    check("fw_hold",   32'(if_f.r_data), 32'hA5);
    if_f.re = 1'b1;
    tick();
    if_f.re = 1'b0;
    check("fw_pop_rvalid", 32'(if_f.r_valid), 0);
    check("fw_pop_empty",  32'(if_f.empty), 1);
    check("fw_pop_unr",    32'(if_f.underrun), 0);
    if_f.we = 1'b1; if_f.w_data = 8'h11;
    tick();
    if_f.w_data = 8'h22;
    tick();
    if_f.we = 1'b0;
    check("fw_head1", 32'(if_f.r_data), 32'h11);
    if_f.re = 1'b1;
    tick();
    if_f.re = 1'b0;
    check("fw_head2",   32'(if_f.r_data), 32'h22);
    check("fw_count",   32'(if_f.count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. It is the next generation of the fixed 8-entry, 8-bit FIFO.
- Generalised in width and depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overrun/underrun error flags with a clear, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain as the general-purpose buffering block.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; power of two, >= 2
AF_THRESH, 14, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1, must be < AF_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset
we  input  1  write request
w_data  input  DATA_WIDTH  write data
re  input  1  read request / pop
r_data  output  DATA_WIDTH  read data
r_valid  output  1  r_data holds a valid word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
overrun  output  1  sticky: write attempted while full and not accepted
underrun  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overrun/underrun

Behaviour:
- Reset (rst=0, asynchronous):
  - wp, rp and count go to 0; r_data=0; r_valid=0; overrun=0; underrun=0.
  - Flags follow: empty=1, full=0, almost_empty=1 (AE_THRESH >= 0), almost_full=0.
  - Storage is not reset.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is tracked in the count register, not by pointer comparison.
- rd_ok = re && !empty.
- wr_ok = we && (!full || rd_ok).
  - A simultaneous read and write when full is legal: both are accepted and count is unchanged.
- Empty with we=1 and re=1: the write is accepted and the read is rejected. underrun sets, count becomes 1.
- Count update per edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- All flags are decoded combinationally from the registered count. They therefore reflect an accepted operation one cycle after the edge.
- Standard mode (FWFT=0):
  - On rd_ok, r_data <= mem[rp] at the edge.
  - r_valid is high for exactly the following cycle, then returns to 0.
  - r_data holds its last value when no read occurs.
  - Read latency is 1 cycle from re sampled.
- FWFT mode (FWFT=1):
  - r_data = mem[rp], combinational.
  - r_valid = !empty.
  - re acts as a pop acknowledge: on rd_ok, rp advances and the next word appears after the edge.
  - A word written into an empty FIFO is visible on r_data the cycle after the write edge.
- Error flags:
  - overrun <= 1 on we && full && !rd_ok.
  - underrun <= 1 on re && empty.
  - clr_err=1 clears both at the edge; if set and clear occur in the same cycle, set wins.
  - The rejected operation changes no pointer, count or data.
- Reset mid-operation: all state returns to reset values immediately; any in-flight r_valid is dropped.
- Elaboration: an illegal parameter combination (non-power-of-two DEPTH, AE_THRESH >= AF_THRESH) triggers $error.

Decomposition:
- fifo_pkg holds:
  - a ptr_w(DEPTH) / cnt_w(DEPTH) width helper function;
  - the mode constants FIFO_STD=0 and FIFO_FWFT=1;
  - a fifo_err_t packed struct {overrun, underrun}.
- One sub-module, fifo_ram: a DEPTH x DATA_WIDTH array with a synchronous write port and an asynchronous read port. The top handles the registered read for FWFT=0.

Test Plan:
- Reset release with DEPTH=16, then 16 writes 0x01..0x10 -> count=16, full=1; almost_full first high the cycle after the 14th write; empty=0.
- Write at full (16 entries, we=1, re=0) -> overrun=1, count stays 16; then 16 reads (FWFT=0) -> r_data 0x01..0x10 in order, each with r_valid one cycle after re; empty=1; then clr_err -> overrun=0.
- Read at empty with we=1 and re=1 in the same cycle -> underrun=1, count=1, next read returns the written word.
- Full with we=1 and re=1 in the same cycle -> count stays 16, no overrun, head word out, new word enters at the tail. Also run 40 continuous writes and reads to exercise pointer wrap -> data order preserved.
- FWFT=1: write 0xA5 into empty -> next cycle r_valid=1, r_data=0xA5 with no re; pulse re -> r_valid=0, empty=1.
- Assert rst=0 mid-stream at count=9 -> count=0, empty=1, r_valid=0 asynchronously, without waiting for a clock edge.
